// File: rtl/rl_pair_scheduler_pkg.sv
// Shared constants for the pair scheduler: FSM state encoding
// and the default position-BRAM address width.
package rl_pair_scheduler_pkg;

    localparam int ADDR_WIDTH_DEF = 9;

    typedef logic [1:0] state_t;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_ISSUE = 2'b01;
    localparam logic [1:0] S_DRAIN = 2'b10;
    localparam logic [1:0] S_DONE  = 2'b11;

endpackage

// File: rtl/rl_pair_scheduler_if.sv
// Control/status bundle of the pair scheduler.
// master: sweep controller (start/abort/stall/bounds in, status out)
// slave : rl_pair_scheduler (drives addresses, rden, r2_enable, status)
interface rl_pair_scheduler_if
    import rl_pair_scheduler_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int CNT_WIDTH  = 2 * ADDR_WIDTH
);

    logic                  start;
    logic                  abort;
    logic                  stall;
    logic [ADDR_WIDTH-1:0] home_last;
    logic [ADDR_WIDTH-1:0] neighbor_last;
    logic [ADDR_WIDTH-1:0] home_rdaddr;
    logic [ADDR_WIDTH-1:0] neighbor_rdaddr;
    logic                  rden;
    logic                  r2_enable;
    logic                  busy;
    logic                  done;
    logic [CNT_WIDTH-1:0]  pair_count;

    modport master (
        output start, abort, stall, home_last, neighbor_last,
        input  home_rdaddr, neighbor_rdaddr, rden, r2_enable,
        input  busy, done, pair_count
    );

    modport slave (
        input  start, abort, stall, home_last, neighbor_last,
        output home_rdaddr, neighbor_rdaddr, rden, r2_enable,
        output busy, done, pair_count
    );

endinterface

// File: rtl/rl_pair_addr_gen.sv
// Nested home/neighbor address counters (neighbor inner) with
// latched bounds, last-pair and self-pair detection.
// Ports: clk, rst (async active-low), clr_i (latch bounds, zero
// addresses), adv_i (step one pair), *_last_i bounds, home_o/nb_o
// addresses, last_o (at final pair), self_o (home == neighbor).
module rl_pair_addr_gen
    import rl_pair_scheduler_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  adv_i,
    input  logic [ADDR_WIDTH-1:0] home_last_i,
    input  logic [ADDR_WIDTH-1:0] nb_last_i,
    output logic [ADDR_WIDTH-1:0] home_o,
    output logic [ADDR_WIDTH-1:0] nb_o,
    output logic                  last_o,
    output logic                  self_o
);

    localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] home_q, home_d;
    logic [ADDR_WIDTH-1:0] nb_q, nb_d;
    logic [ADDR_WIDTH-1:0] home_last_q, home_last_d;
    logic [ADDR_WIDTH-1:0] nb_last_q, nb_last_d;

    assign last_o = (home_q == home_last_q) && (nb_q == nb_last_q);
    assign self_o = (home_q == nb_q);
    assign home_o = home_q;
    assign nb_o   = nb_q;

    always_comb begin
        home_d      = home_q;
        nb_d        = nb_q;
        home_last_d = home_last_q;
        nb_last_d   = nb_last_q;
        if (clr_i) begin
            home_last_d = home_last_i;
            nb_last_d   = nb_last_i;
            home_d      = '0;
            nb_d        = '0;
        end else if (adv_i) begin
            // final pair returns both counters to 0
            if (last_o) begin
                home_d = '0;
                nb_d   = '0;
            end else if (nb_q == nb_last_q) begin
                nb_d   = '0;
                home_d = home_q + ONE;
            end else begin
                nb_d = nb_q + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            home_q      <= '0;
            nb_q        <= '0;
            home_last_q <= '0;
            nb_last_q   <= '0;
        end else begin
            home_q      <= home_d;
            nb_q        <= nb_d;
            home_last_q <= home_last_d;
            nb_last_q   <= nb_last_d;
        end
    end

endmodule

// File: rtl/rl_pair_scheduler.sv
// Issues every (home, neighbor) position pair once per sweep, with
// stall/abort, one-cycle drain for the r2 stage and a done pulse.
// Ports: clk, rst (async active-low), bus (rl_pair_scheduler_if.slave).
// Option: define RL_SKIP_SELF_PAIR_EN to suppress home==neighbor pairs.
module rl_pair_scheduler
    import rl_pair_scheduler_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int CNT_WIDTH  = 2 * ADDR_WIDTH
) (
    input logic                   clk,
    input logic                   rst,
    rl_pair_scheduler_if.slave    bus
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 r2_q;

    logic                  clr;
    logic                  adv;
    logic                  skip;
    logic                  rden;
    logic                  last;
    logic                  self_pair;
    logic [ADDR_WIDTH-1:0] home_addr;
    logic [ADDR_WIDTH-1:0] nb_addr;

    assign clr = (state_q == S_IDLE) && bus.start;
    // abort cancels the step too, so addresses and count freeze
    assign adv = (state_q == S_ISSUE) && !bus.stall && !bus.abort;

`ifdef RL_SKIP_SELF_PAIR_EN
    assign skip = self_pair;
`else
    assign skip = 1'b0;
`endif

    assign rden = adv && !skip;

    rl_pair_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (clr),
        .adv_i       (adv),
        .home_last_i (bus.home_last),
        .nb_last_i   (bus.neighbor_last),
        .home_o      (home_addr),
        .nb_o        (nb_addr),
        .last_o      (last),
        .self_o      (self_pair)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.start) state_d = S_ISSUE;
            S_ISSUE: begin
                if (bus.abort)
                    state_d = S_IDLE;
                else if (!bus.stall && last)
                    state_d = S_DRAIN;
            end
            S_DRAIN: state_d = bus.abort ? S_IDLE : S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (rden)
            cnt_d = cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            r2_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r2_q    <= rden;
        end
    end

    assign bus.home_rdaddr     = home_addr;
    assign bus.neighbor_rdaddr = nb_addr;
    assign bus.rden            = rden;
    assign bus.r2_enable       = r2_q;
    assign bus.busy            = (state_q != S_IDLE);
    assign bus.done            = (state_q == S_DONE);
    assign bus.pair_count      = cnt_q;

endmodule

// File: tb/tb_rl_pair_scheduler.sv
// Randomized bench for rl_pair_scheduler against a nested-loop
// pair-list model; honours RL_SKIP_SELF_PAIR_EN.
module tb_rl_pair_scheduler;

    localparam int AW = 9;
    localparam int CW = 2 * AW;

`ifdef RL_SKIP_SELF_PAIR_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rl_pair_scheduler_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

    rl_pair_scheduler #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int nvec = 0;
    int nerr = 0;

    int obs_h[$];
    int obs_n[$];
    int exp_h[$];
    int exp_n[$];
    bit rden_tr[$];
    bit r2_tr[$];
    bit done_tr[$];
    bit busy_tr[$];
    int exp_done_k;
    int final_cnt;
    bit timed_out;

    // Model: every pair in neighbor-inner order, minus self pairs when skipping
    task automatic build_expected(input int hl, input int nl);
        exp_h.delete();
        exp_n.delete();
        for (int h = 0; h <= hl; h++)
            for (int n = 0; n <= nl; n++)
                if (!(SKIP && h == n)) begin
                    exp_h.push_back(h);
                    exp_n.push_back(n);
                end
    endtask

    // Drives one sweep and records what the DUT does each cycle.
    task automatic run_sweep(input int hl, input int nl, input int stall_pct,
                             input int stall_mask, input int abort_after,
                             input int start_mid);
        int  k;
        int  steps;
        bit  aborted;
        bit  was_aborted;
        bit  ended;
        obs_h.delete(); obs_n.delete();
        rden_tr.delete(); r2_tr.delete(); done_tr.delete(); busy_tr.delete();
        build_expected(hl, nl);
        @(negedge clk);
        bus.home_last     = AW'(hl);
        bus.neighbor_last = AW'(nl);
        bus.start = 1'b1;
        bus.stall = 1'b0;
        bus.abort = 1'b0;
        @(posedge clk);
        steps = (hl + 1) * (nl + 1);
        exp_done_k = -1;
        k = 0;
        aborted = 1'b0;
        ended = 1'b0;
        timed_out = 1'b0;
        while (!ended) begin
            @(negedge clk);
            was_aborted = aborted;
            bus.start = (k == start_mid);
            bus.abort = (abort_after > 0 && !aborted &&
                         obs_h.size() == abort_after);
            bus.stall = 1'b0;
            if (bus.abort) aborted = 1'b1;
            if (steps > 0 && !bus.abort) begin
                bus.stall = ((k < 32) && stall_mask[k]) ||
                            ($urandom_range(0, 99) < stall_pct);
                if (!bus.stall) begin
                    steps--;
                    if (steps == 0) exp_done_k = k + 2;
                end
            end
            #1;
            rden_tr.push_back(bus.rden);
            r2_tr.push_back(bus.r2_enable);
            done_tr.push_back(bus.done);
            busy_tr.push_back(bus.busy);
            if (bus.rden) begin
                obs_h.push_back(int'(bus.home_rdaddr));
                obs_n.push_back(int'(bus.neighbor_rdaddr));
            end
            final_cnt = int'(bus.pair_count);
            if (was_aborted || bus.done) ended = 1'b1;
            k++;
            if (k > 1000) begin
                timed_out = 1'b1;
                ended = 1'b1;
            end
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.stall = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.stall = 1'b0;
        bus.home_last = '0; bus.neighbor_last = '0;
        #12;
        nvec++;
        if ({bus.rden, bus.r2_enable, bus.busy, bus.done} !== 4'b0) begin
            nerr++;
            $display("FAIL reset_flags got %b want 0000",
                     {bus.rden, bus.r2_enable, bus.busy, bus.done});
        end
        nvec++;
        if (bus.pair_count !== '0 || bus.home_rdaddr !== '0 ||
            bus.neighbor_rdaddr !== '0) begin
            nerr++;
            $display("FAIL reset_regs cnt=%0d h=%0d n=%0d want 0 0 0",
                     bus.pair_count, bus.home_rdaddr, bus.neighbor_rdaddr);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic;
        int ok;
        int dk;
        run_sweep(1, 2, 0, 0, 0, -1);
        nvec++;
        ok = (obs_h.size() == 6);
        for (int i = 0; ok && i < 6; i++)
            if (obs_h[i] != exp_h[i] || obs_n[i] != exp_n[i]) ok = 0;
        if (!ok) begin
            nerr++;
            $display("FAIL basic_seq got %0d pairs want 6 in order", obs_h.size());
        end
        nvec++;
        ok = (rden_tr.size() > 6);
        for (int i = 0; ok && i < 6; i++) if (!rden_tr[i]) ok = 0;
        if (ok && rden_tr[6]) ok = 0;
        if (!ok) begin
            nerr++;
            $display("FAIL basic_rden_run got broken run want 6 consecutive");
        end
        dk = -1;
        foreach (done_tr[i]) if (done_tr[i] && dk < 0) dk = i;
        nvec++;
        if (dk != 7 || timed_out) begin
            nerr++;
            $display("FAIL basic_done_cycle got %0d want 7", dk);
        end
        nvec++;
        if (final_cnt != 6) begin
            nerr++;
            $display("FAIL basic_count got %0d want 6", final_cnt);
        end
        nvec++;
        ok = 1;
        foreach (busy_tr[i]) if (!busy_tr[i]) ok = 0;
        if (!ok) begin
            nerr++;
            $display("FAIL basic_busy got a low busy mid-sweep want 1");
        end
    endtask

    task automatic test_stall;
        bit exp_r[8];
        int ok;
        int prev;
        exp_r = '{1, 0, 1, 0, 1, 1, 1, 1};
        run_sweep(1, 2, 0, 32'b1010, 0, -1);
        nvec++;
        ok = (rden_tr.size() >= 9);
        for (int i = 0; ok && i < 8; i++) if (rden_tr[i] != exp_r[i]) ok = 0;
        if (ok && rden_tr[8]) ok = 0;
        if (!ok) begin
            nerr++;
            $display("FAIL stall_rden_pattern got wrong gaps want 10101111");
        end
        nvec++;
        ok = (obs_h.size() == exp_h.size());
        for (int i = 0; ok && i < obs_h.size(); i++)
            if (obs_h[i] != exp_h[i] || obs_n[i] != exp_n[i]) ok = 0;
        if (!ok) begin
            nerr++;
            $display("FAIL stall_seq got %0d pairs want 6 in order", obs_h.size());
        end
        nvec++;
        ok = 1;
        prev = 0;
        foreach (r2_tr[i]) begin
            if (r2_tr[i] != prev) ok = 0;
            prev = rden_tr[i];
        end
        if (!ok) begin
            nerr++;
            $display("FAIL stall_r2_trail got r2 not rden delayed want 1-cycle lag");
        end
        nvec++;
        if (final_cnt != 6) begin
            nerr++;
            $display("FAIL stall_count got %0d want 6", final_cnt);
        end
    endtask

    task automatic test_self_pair;
        int ok;
        int want;
        want = SKIP ? 6 : 9;
        run_sweep(2, 2, 25, 0, 0, -1);
        nvec++;
        if (final_cnt != want) begin
            nerr++;
            $display("FAIL self_count got %0d want %0d", final_cnt, want);
        end
        nvec++;
        ok = (obs_h.size() == want);
        for (int i = 0; ok && i < obs_h.size(); i++)
            if (SKIP && obs_h[i] == obs_n[i]) ok = 0;
        if (!ok) begin
            nerr++;
            $display("FAIL self_pairs got %0d issued want %0d", obs_h.size(), want);
        end
    endtask

    task automatic test_abort;
        int dn;
        run_sweep(2, 3, 0, 0, 3, -1);
        dn = 0;
        foreach (done_tr[i]) if (done_tr[i]) dn++;
        nvec++;
        if (dn != 0) begin
            nerr++;
            $display("FAIL abort_no_done got %0d pulses want 0", dn);
        end
        nvec++;
        if (busy_tr[busy_tr.size() - 1] !== 1'b0) begin
            nerr++;
            $display("FAIL abort_busy got 1 want 0");
        end
        nvec++;
        if (final_cnt != 3) begin
            nerr++;
            $display("FAIL abort_count got %0d want 3", final_cnt);
        end
        run_sweep(1, 1, 0, 0, 0, -1);
        nvec++;
        if (obs_h.size() == 0 || obs_h[0] != 0 || obs_n[0] != 0) begin
            nerr++;
            $display("FAIL abort_restart got first pair missing/nonzero want (0,0)");
        end
    endtask

    task automatic test_single;
        int dk;
        run_sweep(0, 0, 0, 0, 0, -1);
        dk = -1;
        foreach (done_tr[i]) if (done_tr[i] && dk < 0) dk = i;
        nvec++;
        if (obs_h.size() != 1 || final_cnt != 1) begin
            nerr++;
            $display("FAIL single_pair got %0d rden/%0d count want 1/1",
                     obs_h.size(), final_cnt);
        end
        nvec++;
        if (dk != 2) begin
            nerr++;
            $display("FAIL single_done_cycle got %0d want 2", dk);
        end
    endtask

    task automatic test_start_busy;
        int ok;
        run_sweep(2, 3, 20, 0, 0, 2);
        nvec++;
        ok = (obs_h.size() == exp_h.size()) && (final_cnt == exp_h.size());
        for (int i = 0; ok && i < obs_h.size(); i++)
            if (obs_h[i] != exp_h[i] || obs_n[i] != exp_n[i]) ok = 0;
        if (!ok) begin
            nerr++;
            $display("FAIL start_busy got %0d pairs cnt %0d want %0d",
                     obs_h.size(), final_cnt, exp_h.size());
        end
    endtask

    task automatic test_reset_mid;
        int ok;
        @(negedge clk);
        bus.home_last = AW'(3);
        bus.neighbor_last = AW'(3);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        nvec++;
        if ({bus.rden, bus.r2_enable, bus.busy, bus.done} !== 4'b0 ||
            bus.pair_count !== '0 || bus.home_rdaddr !== '0 ||
            bus.neighbor_rdaddr !== '0) begin
            nerr++;
            $display("FAIL reset_mid got cnt=%0d busy=%b rden=%b want all 0",
                     bus.pair_count, bus.busy, bus.rden);
        end
        @(negedge clk);
        rst = 1'b1;
        ok = 1;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (bus.busy || bus.rden) ok = 0;
        end
        nvec++;
        if (!ok) begin
            nerr++;
            $display("FAIL reset_idle got busy/rden high want idle");
        end
        run_sweep(1, 1, 0, 0, 0, -1);
        nvec++;
        if (final_cnt != exp_h.size() || obs_h.size() == 0 || obs_h[0] != 0) begin
            nerr++;
            $display("FAIL reset_resweep got cnt %0d want %0d",
                     final_cnt, exp_h.size());
        end
    endtask

    task automatic test_random;
        int hl;
        int nl;
        int ok;
        int dk;
        int dn;
        int prev;
        for (int t = 0; t < 8; t++) begin
            hl = $urandom_range(0, 4);
            nl = $urandom_range(0, 4);
            run_sweep(hl, nl, 30, 0, 0, -1);
            nvec++;
            ok = !timed_out && (obs_h.size() == exp_h.size());
            for (int i = 0; ok && i < obs_h.size(); i++)
                if (obs_h[i] != exp_h[i] || obs_n[i] != exp_n[i]) ok = 0;
            if (!ok) begin
                nerr++;
                $display("FAIL rand_seq[%0d] hl=%0d nl=%0d got %0d pairs want %0d",
                         t, hl, nl, obs_h.size(), exp_h.size());
            end
            nvec++;
            if (final_cnt != exp_h.size()) begin
                nerr++;
                $display("FAIL rand_count[%0d] got %0d want %0d",
                         t, final_cnt, exp_h.size());
            end
            dk = -1;
            dn = 0;
            foreach (done_tr[i]) if (done_tr[i]) begin
                dn++;
                if (dk < 0) dk = i;
            end
            nvec++;
            if (dk != exp_done_k || dn != 1) begin
                nerr++;
                $display("FAIL rand_done[%0d] got k=%0d n=%0d want k=%0d n=1",
                         t, dk, dn, exp_done_k);
            end
            nvec++;
            ok = 1;
            prev = 0;
            foreach (r2_tr[i]) begin
                if (r2_tr[i] != prev) ok = 0;
                prev = rden_tr[i];
            end
            if (!ok) begin
                nerr++;
                $display("FAIL rand_r2[%0d] got r2 not lagging rden want 1-cycle lag", t);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_self_pair();
        test_abort();
        test_single();
        test_start_busy();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
